// File: rtl/led7_scan_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver.
// Segment bus width, decimal-point bit and scan FSM encodings.
package led7_scan_pkg;

  localparam int SEG_W  = 8;
  localparam int DP_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/led7_scan_tick.sv
// Slot timer: free-running 0..DIV-1 counter with synchronous clear.
// wrap is high while the counter sits on its last value.
module scan_tick #(
  parameter int DIV = 50000,
  parameter int TW  = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  output logic [TW-1:0] tick,
  output logic          wrap
);

  localparam logic [TW-1:0] LAST = TW'(DIV - 1);

  assign wrap = (tick == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick <= '0;
    end else if (clr || wrap) begin
      tick <= '0;
    end else begin
      tick <= tick + TW'(1);
    end
  end

endmodule

// File: rtl/led7_scan.sv
// Time-multiplexed 7-segment driver: one digit per slot, blanking
// at slot start, patterns snapshotted once per frame.
module led7_scan
  import led7_scan_pkg::*;
#(
  parameter int COUNT          = 6,
  parameter int DIV            = 50000,
  parameter int BLANK          = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [COUNT*SEG_W-1:0] leds,
  output logic [SEG_W-1:0]       seg,
  output logic [COUNT-1:0]       dig,
  output logic                   frame_start
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (COUNT > 1) ? $clog2(COUNT) : 1;

  localparam logic [TW-1:0] BLANK_END =
    TW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(COUNT - 1);
  localparam logic [COUNT-1:0] DIG_ONE = COUNT'(1);

  // XOR masks: pattern ^ mask gives the bus level; zero pattern = off
  localparam logic [SEG_W-1:0] SEG_OFF = {SEG_W{SEG_ACTIVE_LOW}};
  localparam logic [COUNT-1:0] DIG_OFF = {COUNT{DIG_ACTIVE_LOW}};

  if (COUNT < 1 || DIV < 2 || BLANK < 0 || BLANK >= DIV) begin : g_bad
    $error("led7_scan: illegal COUNT/DIV/BLANK combination");
  end

  scan_state_t state, state_nx;

  logic [IW-1:0]          idx, idx_nx;
  logic [COUNT*SEG_W-1:0] shadow;
  logic [TW-1:0]          tick;
  logic                   wrap;
  logic                   snap;
  logic                   show;
  logic                   clr;
  logic [SEG_W-1:0]       seg_pat;
  logic [COUNT-1:0]       dig_pat;

  assign clr = !en || (state == ST_IDLE);

  scan_tick #(
    .DIV (DIV),
    .TW  (TW)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick),
    .wrap  (wrap)
  );

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    snap     = 1'b0;
    if (!en) begin
      state_nx = ST_IDLE;
      idx_nx   = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          snap     = 1'b1;
          idx_nx   = '0;
          state_nx = (BLANK == 0) ? ST_SHOW : ST_BLANK;
        end
        ST_BLANK: begin
          if (tick == BLANK_END) state_nx = ST_SHOW;
        end
        ST_SHOW: begin
          if (wrap) begin
            state_nx = (BLANK == 0) ? ST_SHOW : ST_BLANK;
            if (idx == IDX_LAST) begin
              idx_nx = '0;
              snap   = 1'b1;
            end else begin
              idx_nx = idx + IW'(1);
            end
          end
        end
        default: begin
          state_nx = ST_IDLE;
          idx_nx   = '0;
        end
      endcase
    end
  end

  // en gates the output stage too, so a drop blanks on the very next cycle
  assign show    = en && (state == ST_SHOW);
  assign seg_pat = shadow[idx*SEG_W +: SEG_W];
  assign dig_pat = DIG_ONE << idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      shadow      <= '0;
      frame_start <= 1'b0;
      seg         <= SEG_OFF;
      dig         <= DIG_OFF;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      frame_start <= snap;
      if (snap) shadow <= leds;
      if (show) begin
        seg <= seg_pat ^ SEG_OFF;
        dig <= dig_pat ^ DIG_OFF;
      end else begin
        seg <= SEG_OFF;
        dig <= DIG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_led7_scan.sv
// Bench for led7_scan: cycle scoreboard from a frame-position model
// plus a table of hand-derived checkpoints for the directed scenarios.
module tb_led7_scan;

  localparam int COUNT = 3;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int LOGN  = 512;

  typedef struct {
    logic [7:0] seg;
    logic [2:0] dig;
    logic       fs;
  } exp_t;

  typedef struct {
    int         k;
    logic [7:0] seg;
    logic [2:0] dig;
    logic       fs;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [23:0] leds;
  logic [7:0]  seg0, seg1;
  logic [2:0]  dig0, dig1;
  logic        fs0, fs1;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int base   = 0;

  exp_t q0[$];
  exp_t q1[$];
  vec_t t0[$];
  vec_t t1[$];

  bit          m_act [2];
  int          m_pos [2];
  logic [23:0] m_sh  [2];

  logic [7:0] lg_seg [2][LOGN];
  logic [2:0] lg_dig [2][LOGN];
  logic       lg_fs  [2][LOGN];

  always #5 clk = ~clk;

  led7_scan #(
    .COUNT(COUNT), .DIV(DIV), .BLANK(BLANK),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .leds(leds),
    .seg(seg0), .dig(dig0), .frame_start(fs0)
  );

  led7_scan #(
    .COUNT(COUNT), .DIV(DIV), .BLANK(0),
    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
  ) u_pol (
    .clk(clk), .rst_n(rst_n), .en(en), .leds(leds),
    .seg(seg1), .dig(dig1), .frame_start(fs1)
  );

  // Model: position within the running scan since the last snapshot start
  task automatic model_step(input int u, input int blank,
                            input bit sl, input bit dl,
                            output exp_t e);
    logic [7:0] pat;
    logic [2:0] oh;
    int tk, slot;
    pat  = '0;
    oh   = '0;
    e.fs = 1'b0;
    if (!rst_n) begin
      m_act[u] = 1'b0;
      m_pos[u] = 0;
      m_sh[u]  = '0;
    end else if (!en) begin
      m_act[u] = 1'b0;
      m_pos[u] = 0;
    end else if (!m_act[u]) begin
      m_act[u] = 1'b1;
      m_pos[u] = 0;
      m_sh[u]  = leds;
      e.fs     = 1'b1;
    end else begin
      tk   = m_pos[u] % DIV;
      slot = (m_pos[u] / DIV) % COUNT;
      if (tk >= blank) begin
        pat = m_sh[u][slot*8 +: 8];
        oh  = 3'b001;
        oh  = oh << slot;
      end
      m_pos[u]++;
      if (m_pos[u] % (COUNT*DIV) == 0) begin
        m_sh[u] = leds;
        e.fs    = 1'b1;
      end
    end
    e.seg = sl ? ~pat : pat;
    e.dig = dl ? ~oh : oh;
  endtask

  always @(posedge clk) begin : p_model
    exp_t e;
    edge_n++;
    model_step(0, BLANK, 1'b1, 1'b1, e);
    q0.push_back(e);
    model_step(1, 0, 1'b0, 1'b0, e);
    q1.push_back(e);
  end

  task automatic cmp(input string nm, input logic [7:0] s,
                     input logic [2:0] d, input logic f,
                     input exp_t e);
    checks++;
    if (s !== e.seg || d !== e.dig || f !== e.fs) begin
      errors++;
      $display("FAIL %s edge %0d: got seg=%h dig=%b fs=%b, want seg=%h dig=%b fs=%b",
               nm, edge_n, s, d, f, e.seg, e.dig, e.fs);
    end
  endtask

  always @(negedge clk) begin : p_mon
    exp_t e;
    if (edge_n > 0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb0 edge %0d: got empty queue, want entry", edge_n);
      end else begin
        e = q0.pop_front();
        cmp("sb0", seg0, dig0, fs0, e);
      end
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb1 edge %0d: got empty queue, want entry", edge_n);
      end else begin
        e = q1.pop_front();
        cmp("sb1", seg1, dig1, fs1, e);
      end
      checks++;
      if ($countones(~dig0) > 1 || (dig0 == 3'b111 && seg0 != 8'hFF)) begin
        errors++;
        $display("FAIL onehot0 edge %0d: got seg=%h dig=%b, want <=1 digit and blank seg when idle",
                 edge_n, seg0, dig0);
      end
      checks++;
      if ($countones(dig1) > 1 || (dig1 == 3'b000 && seg1 != 8'h00)) begin
        errors++;
        $display("FAIL onehot1 edge %0d: got seg=%h dig=%b, want <=1 digit and blank seg when idle",
                 edge_n, seg1, dig1);
      end
      if (edge_n < LOGN) begin
        lg_seg[0][edge_n] = seg0;
        lg_dig[0][edge_n] = dig0;
        lg_fs[0][edge_n]  = fs0;
        lg_seg[1][edge_n] = seg1;
        lg_dig[1][edge_n] = dig1;
        lg_fs[1][edge_n]  = fs1;
      end
    end
  end

  function automatic vec_t mk(input int k, input logic [7:0] s,
                              input logic [2:0] d, input logic f);
    vec_t v;
    v.k = k; v.seg = s; v.dig = d; v.fs = f;
    return v;
  endfunction

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_table(input int u, input string nm);
    vec_t v;
    int ix;
    int n;
    n = (u == 0) ? t0.size() : t1.size();
    for (int i = 0; i < n; i++) begin
      v  = (u == 0) ? t0[i] : t1[i];
      ix = base + v.k;
      checks++;
      if (ix >= LOGN || lg_seg[u][ix] !== v.seg ||
          lg_dig[u][ix] !== v.dig || lg_fs[u][ix] !== v.fs) begin
        errors++;
        $display("FAIL %s k=%0d: got seg=%h dig=%b fs=%b, want seg=%h dig=%b fs=%b",
                 nm, v.k, lg_seg[u][ix % LOGN], lg_dig[u][ix % LOGN],
                 lg_fs[u][ix % LOGN], v.seg, v.dig, v.fs);
      end
    end
  endtask

  initial begin
    // k = edges after reset release; outputs lag the scan state by one edge
    t0.push_back(mk(1,  8'hFF, 3'b111, 1'b1));
    t0.push_back(mk(2,  8'hFF, 3'b111, 1'b0));
    t0.push_back(mk(3,  8'hFF, 3'b111, 1'b0));
    t0.push_back(mk(4,  8'hC3, 3'b110, 1'b0));
    t0.push_back(mk(9,  8'hC3, 3'b110, 1'b0));
    t0.push_back(mk(10, 8'hFF, 3'b111, 1'b0));
    t0.push_back(mk(12, 8'hA5, 3'b101, 1'b0));
    t0.push_back(mk(17, 8'hA5, 3'b101, 1'b0));
    t0.push_back(mk(18, 8'hFF, 3'b111, 1'b0));
    t0.push_back(mk(20, 8'hF0, 3'b011, 1'b0));
    t0.push_back(mk(25, 8'hF0, 3'b011, 1'b1));
    t0.push_back(mk(26, 8'hFF, 3'b111, 1'b0));
    t0.push_back(mk(28, 8'hC3, 3'b110, 1'b0));
    t0.push_back(mk(36, 8'hA5, 3'b101, 1'b0));
    t0.push_back(mk(44, 8'hF0, 3'b011, 1'b0));
    t0.push_back(mk(49, 8'hF0, 3'b011, 1'b1));
    t0.push_back(mk(52, 8'h00, 3'b110, 1'b0));
    t0.push_back(mk(69, 8'h00, 3'b011, 1'b0));
    t0.push_back(mk(70, 8'hFF, 3'b111, 1'b0));
    t0.push_back(mk(71, 8'hFF, 3'b111, 1'b0));
    t0.push_back(mk(72, 8'hFF, 3'b111, 1'b1));
    t0.push_back(mk(75, 8'hCC, 3'b110, 1'b0));
    t0.push_back(mk(85, 8'hDD, 3'b101, 1'b0));
    t0.push_back(mk(86, 8'hFF, 3'b111, 1'b0));
    t0.push_back(mk(87, 8'hFF, 3'b111, 1'b0));
    t0.push_back(mk(88, 8'hFF, 3'b111, 1'b1));
    t0.push_back(mk(91, 8'hCC, 3'b110, 1'b0));

    t1.push_back(mk(1,  8'h00, 3'b000, 1'b1));
    t1.push_back(mk(2,  8'h3C, 3'b001, 1'b0));
    t1.push_back(mk(9,  8'h3C, 3'b001, 1'b0));
    t1.push_back(mk(10, 8'h5A, 3'b010, 1'b0));
    t1.push_back(mk(18, 8'h0F, 3'b100, 1'b0));
    t1.push_back(mk(25, 8'h0F, 3'b100, 1'b1));
    t1.push_back(mk(26, 8'h3C, 3'b001, 1'b0));
    t1.push_back(mk(69, 8'hFF, 3'b100, 1'b0));
    t1.push_back(mk(70, 8'h00, 3'b000, 1'b0));
    t1.push_back(mk(72, 8'h00, 3'b000, 1'b1));
    t1.push_back(mk(73, 8'h33, 3'b001, 1'b0));

    rst_n = 1'b0;
    en    = 1'b1;
    leds  = 24'h0F_5A_3C;
    tick_n(3);
    rst_n = 1'b1;
    base  = edge_n;
    tick_n(33);
    leds  = 24'hFF_FF_FF;
    tick_n(22);
    tick_n(14);
    en    = 1'b0;
    tick_n(2);
    en    = 1'b1;
    leds  = 24'h11_22_33;
    tick_n(6);
    tick_n(8);
    rst_n = 1'b0;
    tick_n(2);
    rst_n = 1'b1;
    tick_n(8);

    check_table(0, "tbl_main");
    check_table(1, "tbl_pol");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
